// File: rtl/wb_master_pipelined.sv
// ---------------------------------------------------------------------------
// wb_master_pipelined
//
// Wishbone classic-pipelined bus master. A single burst command is turned
// into back-to-back pipelined strobes. The master honours wb_stall_i and
// limits how many strobes may be accepted but not yet acknowledged. Read
// data and write acceptance are returned to the requester.
//
// Optional feature (compile-time macro WB_MASTER_TIMEOUT_EN):
//   The watchdog counts cycles with cyc high and no ack. It is cleared on
//   every ack and at burst start. When it reaches TIMEOUT, the burst is
//   aborted and err pulses. Without the macro, err is always 0 and a lost
//   ack holds the master in DRAIN until reset.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only when idle)
//   cmd_we/adr/len        burst direction, base word address, beats-1
//   wr_data / wr_ready    current write beat / pulse when slave takes it
//   rd_data / rd_valid    read beat / pulse on each read ack
//   done                  one-cycle pulse after the final ack
//   err                   one-cycle pulse on watchdog abort
//   wb_*                  Wishbone pipelined master interface
// ---------------------------------------------------------------------------
module wb_master_pipelined #(
    parameter int unsigned LEN_W           = 8,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned TIMEOUT         = 255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [15:0]      cmd_adr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [15:0]      wr_data,
    output logic             wr_ready,
    output logic [15:0]      rd_data,
    output logic             rd_valid,
    output logic             done,
    output logic             err,
    output logic             wb_cyc_o,
    output logic             wb_stb_o,
    output logic             wb_we_o,
    output logic [15:0]      wb_adr_o,
    output logic [15:0]      wb_dat_o,
    input  logic [15:0]      wb_dat_i,
    input  logic             wb_ack_i,
    input  logic             wb_stall_i
);

    if (MAX_OUTSTANDING == 0 || MAX_OUTSTANDING > 15 || TIMEOUT == 0) begin : g_param_check
        $error("wb_master_pipelined: MAX_OUTSTANDING must be 1..15 and TIMEOUT nonzero");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    localparam logic [3:0]     MAX_OUT = 4'(MAX_OUTSTANDING);
    localparam logic [LEN_W:0] ONE_BEAT = (LEN_W+1)'(1);

    state_t         state_q;
    logic           we_q;
    logic           cyc_q;
    logic           done_q;
    logic           err_q;
    logic [15:0]    adr_q;
    logic [15:0]    adr_d;
    logic [LEN_W:0] issue_left_q;
    logic [LEN_W:0] ack_left_q;
    logic [LEN_W:0] beats_d;
    logic [3:0]     out_q;
    logic [3:0]     out_d;

    logic busy;
    logic stb;
    logic accept;
    logic ack;
    logic last_ack;

    assign busy     = (state_q != IDLE);
    // Strobe is derived from registered state only, so it never depends
    // combinationally on the slave's ack or stall.
    assign stb      = (state_q == ISSUE) && (issue_left_q != '0) && (out_q < MAX_OUT);
    assign accept   = stb && !wb_stall_i;
    // Acks outside a burst (or beyond the expected count) are ignored.
    assign ack      = busy && wb_ack_i && (ack_left_q != '0);
    assign last_ack = ack && (ack_left_q == ONE_BEAT);

    assign adr_d   = adr_q + 16'd1;
    assign beats_d = {1'b0, cmd_len} + ONE_BEAT;

    // Accept and ack in the same cycle cancel out.
    always_comb begin
        out_d = out_q;
        if (accept && !ack) begin
            out_d = out_q + 4'd1;
        end else if (!accept && ack && (out_q != 4'd0)) begin
            out_d = out_q - 4'd1;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign wb_cyc_o  = cyc_q;
    assign wb_stb_o  = stb;
    assign wb_we_o   = we_q;
    assign wb_adr_o  = adr_q;
    assign wb_dat_o  = (busy && we_q) ? wr_data : 16'h0000;
    assign wr_ready  = accept && we_q;
    assign rd_valid  = ack && !we_q;
    assign rd_data   = rd_valid ? wb_dat_i : 16'h0000;
    assign done      = done_q;
    assign err       = err_q;

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int unsigned WD_W = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    logic [WD_W-1:0] wdog_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            we_q         <= 1'b0;
            cyc_q        <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            adr_q        <= 16'h0000;
            issue_left_q <= '0;
            ack_left_q   <= '0;
            out_q        <= 4'd0;
`ifdef WB_MASTER_TIMEOUT_EN
            wdog_q       <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            out_q  <= out_d;
            if (accept) begin
                adr_q        <= adr_d;
                issue_left_q <= issue_left_q - ONE_BEAT;
            end
            if (ack) begin
                ack_left_q <= ack_left_q - ONE_BEAT;
            end

            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        we_q         <= cmd_we;
                        adr_q        <= cmd_adr;
                        issue_left_q <= beats_d;
                        ack_left_q   <= beats_d;
                        out_q        <= 4'd0;
                        cyc_q        <= 1'b1;
                        state_q      <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (last_ack) begin
                        cyc_q   <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end else if (accept && (issue_left_q == ONE_BEAT)) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (last_ack) begin
                        cyc_q   <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase

`ifdef WB_MASTER_TIMEOUT_EN
            if (!busy || ack) begin
                wdog_q <= '0;
            end else if (wdog_q == WD_LAST) begin
                // Abort: the slave has gone silent for TIMEOUT cycles.
                wdog_q       <= '0;
                cyc_q        <= 1'b0;
                err_q        <= 1'b1;
                issue_left_q <= '0;
                ack_left_q   <= '0;
                out_q        <= 4'd0;
                state_q      <= IDLE;
            end else begin
                wdog_q <= wdog_q + WD_W'(1);
            end
`endif
        end
    end

endmodule
